exec_core: RTL

Parametrised execution core for the toy CPU. It holds a REGS-entry, N-bit register file and decodes `{opcode, rd, rs2, rs1}` instruction words. It executes add/sub/mul/and/or/xor/li in one cycle and div as an N-cycle restoring divider, with a valid/ready input handshake, a writeback strobe and a per-instruction exception flag. It replaces the open-loop mux/demux/functional-unit datapath, which has no back-pressure, no exception reporting and a fixed 16x16 shape.

---
 rtl/exec_core.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/exec_core.sv
// Toy-CPU execution core: register file, one-cycle ALU ops and an N-cycle restoring divider.
// ALU ops retire one edge after accept; div retires N edges after accept with instr_ready held low meanwhile.
module exec_core #(
  parameter int N        = 16,
  parameter int REGS     = 16,
  parameter int ZERO_REG = 1,
  localparam int SEL     = $clog2(REGS),
  localparam int IW      = 4 + 3*SEL
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [IW-1:0]  instr,
  input  logic [N-1:0]   imm,
  output logic           wb_valid,
  output logic [SEL-1:0] wb_rd,
  output logic [N-1:0]   wb_data,
  output logic           wb_exc,
  output logic [N-1:0]   rem_out,
  output logic           busy,
  input  logic [SEL-1:0] dbg_sel,
  output logic [N-1:0]   dbg_data
);
  localparam int CW = $clog2(N);

  typedef enum logic {IDLE, DIV} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   rf_q [REGS];
  logic [N-1:0]   rf_d [REGS];
  logic [N-1:0]   dvd_q, dvd_d, dvs_q, dvs_d, prem_q, prem_d;
  logic [N-1:0]   rem_out_q, rem_out_d, wb_data_q, wb_data_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [SEL-1:0] drd_q, drd_d, wb_rd_q, wb_rd_d;
  logic           wb_valid_q, wb_valid_d, wb_exc_q, wb_exc_d;

  logic [3:0]     op;
  logic [SEL-1:0] rd, rs2, rs1;
  logic [N-1:0]   a, b, diff, trial, quot;
  logic [N:0]     sum, shifted;
  logic [2*N-1:0] prod;
  logic           take;

  assign {op, rd, rs2, rs1} = instr;

  assign a        = (ZERO_REG != 0 && rs1 == '0) ? '0 : rf_q[rs1];
  assign b        = (ZERO_REG != 0 && rs2 == '0) ? '0 : rf_q[rs2];
  assign dbg_data = (ZERO_REG != 0 && dbg_sel == '0) ? '0 : rf_q[dbg_sel];

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = a - b;
  assign prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};

  // One restoring step: the partial remainder stays below the divisor, so N bits hold it.
  assign shifted = {prem_q, dvd_q[N-1]};
  assign take    = shifted >= {1'b0, dvs_q};
  assign trial   = take ? N'(shifted - {1'b0, dvs_q}) : shifted[N-1:0];
  assign quot    = {dvd_q[N-2:0], take};

  logic           we, exc;
  logic [SEL-1:0] wa;
  logic [N-1:0]   wd, res;

  always_comb begin
    rf_d       = rf_q;
    state_d    = state_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    prem_d     = prem_q;
    cnt_d      = cnt_q;
    drd_d      = drd_q;
    rem_out_d  = rem_out_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_exc_d   = wb_exc_q;
    we         = 1'b0;
    wa         = rd;
    wd         = '0;
    res        = '0;
    exc        = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          we = 1'b1;
          case (op)
            4'd0: begin res = sum[N-1:0];  exc = sum[N];             end
            4'd1: begin res = diff;        exc = (a < b);            end
            4'd2: begin res = prod[N-1:0]; exc = |prod[2*N-1:N];     end
            4'd3: begin
              if (b == '0) begin
                res       = '1;
                exc       = 1'b1;
                rem_out_d = a;
              end else begin
                we      = 1'b0;
                state_d = DIV;
                dvd_d   = a;
                dvs_d   = b;
                prem_d  = '0;
                cnt_d   = CW'(N-1);
                drd_d   = rd;
              end
            end
            4'd4: res = a & b;
            4'd5: res = a | b;
            4'd6: res = a ^ b;
            4'd7: res = imm;
            default: begin we = 1'b0; exc = 1'b1; end
          endcase
          wd = res;
          if (state_d == IDLE) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd;
            wb_data_d  = res;
            wb_exc_d   = exc;
          end
        end
      end
      default: begin
        prem_d = trial;
        dvd_d  = quot;
        if (cnt_q == '0) begin
          we         = 1'b1;
          wa         = drd_q;
          wd         = quot;
          rem_out_d  = trial;
          wb_valid_d = 1'b1;
          wb_rd_d    = drd_q;
          wb_data_d  = quot;
          wb_exc_d   = 1'b0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
    if (we && !(ZERO_REG != 0 && wa == '0)) rf_d[wa] = wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) rf_q[i] <= '0;
      state_q    <= IDLE;
      dvd_q      <= '0;
      dvs_q      <= '0;
      prem_q     <= '0;
      cnt_q      <= '0;
      drd_q      <= '0;
      rem_out_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_exc_q   <= 1'b0;
    end else begin
      rf_q       <= rf_d;
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      prem_q     <= prem_d;
      cnt_q      <= cnt_d;
      drd_q      <= drd_d;
      rem_out_q  <= rem_out_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_exc_q   <= wb_exc_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign busy        = (state_q == DIV);
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign wb_exc      = wb_exc_q;
  assign rem_out     = rem_out_q;

endmodule
